// File: rtl/mux4way_collector_pkg.sv
// rtl/mux4way_collector_pkg.sv - shared constants and helpers for the 4-way collector
package mux4way_collector_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int HACK_WORD = 16;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // Rotating channel index; the 2-bit truncation gives the 3->0 wrap for free.
  function automatic ch_idx_t rot_idx(input ch_idx_t base, input int k);
    return ch_idx_t'(int'(base) + k);
  endfunction

endpackage

// File: rtl/mux4way_collector_if.sv
// rtl/mux4way_collector_if.sv - four producer channels plus one tagged consumer channel
interface mux4way_collector_if
  import mux4way_collector_pkg::*;
#(
  parameter int WIDTH = HACK_WORD
);

  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_ready;
  logic [WIDTH-1:0]  in_data0;
  logic [WIDTH-1:0]  in_data1;
  logic [WIDTH-1:0]  in_data2;
  logic [WIDTH-1:0]  in_data3;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  ch_idx_t           out_sel;

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux4way_collector_rr_pick4.sv
// rtl/mux4way_collector_rr_pick4.sv - combinational round-robin picker over four requests
module rr_pick4
  import mux4way_collector_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           last,
  output logic [NUM_CH-1:0] gnt_oh,
  output ch_idx_t           gnt_idx,
  output logic              any
);

  // Scan starts one past the previous winner so it gets lowest priority.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!any && req[rot_idx(last, k)]) begin
        any     = 1'b1;
        gnt_idx = rot_idx(last, k);
      end
    end
    if (any) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mux4way_collector.sv
// rtl/mux4way_collector.sv - fair 4:1 stream collector with one registered output stage
module mux4way_collector
  import mux4way_collector_pkg::*;
#(
  parameter int WIDTH = HACK_WORD
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  mux4way_collector_if.slave   io_bus
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  ch_idx_t           r_out_sel;
  ch_idx_t           r_last_grant;

  logic              w_can_load;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_gnt_oh;
  ch_idx_t           w_gnt_idx;
  logic              w_any;
  logic [WIDTH-1:0]  w_mux_data;

  assign w_can_load = !r_out_valid || io_bus.out_ready;
  assign w_req      = io_bus.in_valid & {NUM_CH{w_can_load}};

  rr_pick4 u_pick (
    .req     (w_req),
    .last    (r_last_grant),
    .gnt_oh  (w_gnt_oh),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  always_comb begin
    w_mux_data = io_bus.in_data0;
    case (w_gnt_idx)
      2'd1:    w_mux_data = io_bus.in_data1;
      2'd2:    w_mux_data = io_bus.in_data2;
      2'd3:    w_mux_data = io_bus.in_data3;
      default: w_mux_data = io_bus.in_data0;
    endcase
  end

  // last_grant resets to 3 so channel 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_last_grant <= ch_idx_t'(NUM_CH - 1);
    end else if (w_any) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_mux_data;
      r_out_sel    <= w_gnt_idx;
      r_last_grant <= w_gnt_idx;
    end else if (io_bus.out_ready && r_out_valid) begin
      r_out_valid  <= 1'b0;
    end
  end

  // The grant would otherwise show during reset because the empty register can load.
  assign io_bus.in_ready  = w_gnt_oh & {NUM_CH{rst_n}};
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux4way_collector.sv
// tb/tb_mux4way_collector.sv - self-checking bench for the 4-way collector
module tb_mux4way_collector;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  int          m_last;
  bit          m_ov;
  logic [15:0] m_od;
  int          m_os;

  mux4way_collector_if #(.WIDTH(16)) bus ();

  mux4way_collector #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] chan_data(input int c);
    case (c)
      0:       return bus.in_data0;
      1:       return bus.in_data1;
      2:       return bus.in_data2;
      default: return bus.in_data3;
    endcase
  endfunction

  function automatic int model_grant();
    if (m_ov && !bus.out_ready) return -1;
    for (int k = 1; k <= 4; k++) begin
      if (bus.in_valid[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_grant();
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_last = 3;
    m_ov   = 1'b0;
    m_od   = 16'h0000;
    m_os   = 0;
  endtask

  task automatic step();
    int          g;
    logic [15:0] d;
    g = model_grant();
    d = (g >= 0) ? chan_data(g) : 16'h0000;
    @(posedge clk);
    if (g >= 0) begin
      m_ov = 1'b1; m_od = d; m_os = g; m_last = g;
    end else if (bus.out_ready && m_ov) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++;
    if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
    total++;
    if (bus.out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel: got %0d want 0", bus.out_sel); end
    total++;
    if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
    bus.in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic [3:0]  er;
    logic [15:0] ed;
    bus.in_data0 = 16'h00A0; bus.in_data1 = 16'h00A1;
    bus.in_data2 = 16'h00A2; bus.in_data3 = 16'h00A3;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      er = model_ready();
      total++;
      if (bus.in_ready !== er) begin bad++; $display("FAIL contention_in_ready[%0d]: got %b want %b", i, bus.in_ready, er); end
      step();
      ed = 16'h00A0 + 16'(i % 4);
      total++;
      if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL contention_valid[%0d]: got %b want 1", i, bus.out_valid); end
      total++;
      if (bus.out_sel !== 2'(i % 4)) begin bad++; $display("FAIL contention_sel[%0d]: got %0d want %0d", i, bus.out_sel, i % 4); end
      total++;
      if (bus.out_data !== ed) begin bad++; $display("FAIL contention_data[%0d]: got %h want %h", i, bus.out_data, ed); end
    end
  endtask

  task automatic test_backpressure();
    int          hs;
    logic [15:0] hd;
    hs = m_os;
    hd = m_od;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0000", i, bus.in_ready); end
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(hs) || bus.out_data !== hd) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                 i, bus.out_valid, bus.out_sel, bus.out_data, hs, hd);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    step();
    total++;
    if (bus.out_sel !== 2'((hs + 1) % 4)) begin bad++; $display("FAIL stall_release_sel: got %0d want %0d", bus.out_sel, (hs + 1) % 4); end
  endtask

  task automatic test_lone();
    logic [15:0] ed;
    bus.in_valid = 4'b0100;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ed = 16'h1234 + 16'(i);
      bus.in_data2 = ed;
      #1;
      total++;
      if (bus.in_ready !== 4'b0100) begin bad++; $display("FAIL lone_in_ready[%0d]: got %b want 0100", i, bus.in_ready); end
      step();
      total++;
      if (bus.out_sel !== 2'd2 || bus.out_data !== ed) begin
        bad++;
        $display("FAIL lone_beat[%0d]: got sel=%0d data=%h want sel=2 data=%h", i, bus.out_sel, bus.out_data, ed);
      end
    end
  endtask

  task automatic test_sparse_wrap();
    bus.in_data0 = 16'h0D00;
    bus.in_data3 = 16'h0D03;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1000;
    #1; step();
    total++;
    if (bus.out_sel !== 2'd3) begin bad++; $display("FAIL sparse_first_sel: got %0d want 3", bus.out_sel); end
    bus.in_valid = 4'b1001;
    #1; step();
    total++;
    if (bus.out_sel !== 2'd0 || bus.out_data !== 16'h0D00) begin
      bad++; $display("FAIL wrap_sel: got sel=%0d data=%h want sel=0 data=0d00", bus.out_sel, bus.out_data);
    end
    bus.in_valid = 4'b1000;
    #1; step();
    total++;
    if (bus.out_sel !== 2'd3 || bus.out_data !== 16'h0D03) begin
      bad++; $display("FAIL sparse_ch3_sel: got sel=%0d data=%h want sel=3 data=0d03", bus.out_sel, bus.out_data);
    end
    bus.in_valid = 4'b0000;
    #1; step();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", bus.out_valid); end
    total++;
    if (bus.out_sel !== 2'd3 || bus.out_data !== 16'h0D03) begin
      bad++; $display("FAIL drain_hold: got sel=%0d data=%h want sel=3 data=0d03", bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_random();
    bit          pres [4];
    logic [15:0] pd [4];
    logic [15:0] fifo [4][$];
    logic [3:0]  er;
    logic [15:0] got;
    for (int c = 0; c < 4; c++) pres[c] = 1'b0;
    for (int cyc = 0; cyc < 2020; cyc++) begin
      if (cyc < 2000) begin
        for (int c = 0; c < 4; c++) begin
          if (!pres[c] && $urandom_range(0, 1) == 1) begin
            pres[c] = 1'b1;
            pd[c]   = 16'($urandom);
          end
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        for (int c = 0; c < 4; c++) pres[c] = 1'b0;
        bus.out_ready = 1'b1;
      end
      bus.in_data0 = pd[0]; bus.in_data1 = pd[1];
      bus.in_data2 = pd[2]; bus.in_data3 = pd[3];
      bus.in_valid = {pres[3], pres[2], pres[1], pres[0]};
      #1;
      er = model_ready();
      total++;
      if (bus.in_ready !== er) begin bad++; $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, bus.in_ready, er); end
      total++;
      if (!$onehot0(bus.in_ready)) begin bad++; $display("FAIL rand_onehot[%0d]: got %b want one-hot or zero", cyc, bus.in_ready); end
      total++;
      if (bus.out_valid !== m_ov) begin bad++; $display("FAIL rand_out_valid[%0d]: got %b want %b", cyc, bus.out_valid, m_ov); end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        total++;
        if (fifo[bus.out_sel].size() == 0) begin
          bad++; $display("FAIL rand_spurious[%0d]: got beat on sel=%0d want none pending", cyc, bus.out_sel);
        end else begin
          got = fifo[bus.out_sel].pop_front();
          if (bus.out_data !== got) begin
            bad++; $display("FAIL rand_order[%0d]: got %h want %h on sel=%0d", cyc, bus.out_data, got, bus.out_sel);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (bus.in_ready[c] && bus.in_valid[c]) begin
          fifo[c].push_back(pd[c]);
          pres[c] = 1'b0;
        end
      end
      step();
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (fifo[c].size() != 0) begin bad++; $display("FAIL rand_lost[%0d]: got %0d undelivered want 0", c, fifo[c].size()); end
    end
  endtask

  task automatic test_reset_midstream();
    bus.in_valid = 4'b0010;
    bus.in_data1 = 16'hBEEF;
    bus.out_ready = 1'b0;
    #1; step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF) begin
      bad++; $display("FAIL mid_load: got v=%b data=%h want v=1 data=beef", bus.out_valid, bus.out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd0 || bus.out_data !== 16'h0000) begin
      bad++; $display("FAIL mid_async_reset: got v=%b sel=%0d data=%h want v=0 sel=0 data=0000",
                      bus.out_valid, bus.out_sel, bus.out_data);
    end
    model_reset();
    bus.in_valid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1; step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0) begin
      bad++; $display("FAIL mid_restart: got v=%b sel=%0d want v=1 sel=0", bus.out_valid, bus.out_sel);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid = 4'b0000;
    bus.in_data0 = 16'h0000; bus.in_data1 = 16'h0000;
    bus.in_data2 = 16'h0000; bus.in_data3 = 16'h0000;
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_contention();
    test_backpressure();
    test_lone();
    test_sparse_wrap();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
